// File: rtl/lsu_sq.sv
// Store queue: holds issued stores until ROB retirement, then drains them in
// retirement order to the data-cache write port and broadcasts each completion.
module lsu_sq #(
    parameter int SQ_DEPTH   = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    output logic                  o_full,
    input  logic                  i_alloc_en,
    input  logic [TAG_WIDTH-1:0]  i_alloc_tag,
    input  logic [ADDR_WIDTH-1:0] i_alloc_addr,
    input  logic [DATA_WIDTH-1:0] i_alloc_data,
    input  logic [1:0]            i_alloc_lsu_func,
    input  logic                  i_rob_retire_en,
    input  logic [TAG_WIDTH-1:0]  i_rob_retire_tag,
    output logic                  o_dc_wr_en,
    output logic [ADDR_WIDTH-1:0] o_dc_wr_addr,
    output logic [DATA_WIDTH-1:0] o_dc_wr_data,
    output logic [1:0]            o_dc_wr_lsu_func,
    input  logic                  i_dc_wr_done,
    input  logic                  i_dc_wr_retry,
    output logic                  o_sq_retire_en,
    output logic [ADDR_WIDTH-1:0] o_sq_retire_addr,
    output logic [1:0]            o_sq_retire_lsu_func
);

    localparam int IDX_W = $clog2(SQ_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_RETRY,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [SQ_DEPTH-1:0]   slot_valid;
    logic [SQ_DEPTH-1:0]   slot_committed;
    logic [TAG_WIDTH-1:0]  slot_tag  [SQ_DEPTH];
    logic [ADDR_WIDTH-1:0] slot_addr [SQ_DEPTH];
    logic [DATA_WIDTH-1:0] slot_data [SQ_DEPTH];
    logic [1:0]            slot_func [SQ_DEPTH];

    logic [IDX_W-1:0] cfifo [SQ_DEPTH];
    logic [IDX_W:0]   cf_wr_ptr;
    logic [IDX_W:0]   cf_rd_ptr;
    logic             cf_empty;
    logic [IDX_W-1:0] cf_head;

    logic             alloc_found;
    logic             alloc_fire;
    logic [IDX_W-1:0] alloc_idx;
    logic             retire_hit;
    logic [IDX_W-1:0] retire_idx;
    logic [IDX_W-1:0] drain_idx;
    logic             drain_free;
    logic             latch_head;

    always_comb begin
        o_full = &slot_valid;
    end

    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
            if (!slot_valid[i] && !alloc_found) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
        end
        alloc_fire = i_alloc_en && alloc_found && !i_flush;
    end

    always_comb begin
        retire_hit = 1'b0;
        retire_idx = '0;
        for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
            if (i_rob_retire_en && slot_valid[i] && !slot_committed[i] &&
                slot_tag[i] == i_rob_retire_tag) begin
                retire_hit = 1'b1;
                retire_idx = IDX_W'(i);
            end
        end
    end

    // A store retiring in the flush cycle commits and must survive the flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid     <= '0;
            slot_committed <= '0;
        end else begin
            for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
                if (i_flush && slot_valid[i] && !slot_committed[i] &&
                    !(retire_hit && retire_idx == IDX_W'(i)))
                    slot_valid[i] <= 1'b0;
            end
            if (retire_hit)
                slot_committed[retire_idx] <= 1'b1;
            if (drain_free) begin
                slot_valid[drain_idx]     <= 1'b0;
                slot_committed[drain_idx] <= 1'b0;
            end
            if (alloc_fire) begin
                slot_valid[alloc_idx]     <= 1'b1;
                slot_committed[alloc_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            slot_tag[alloc_idx]  <= i_alloc_tag;
            slot_addr[alloc_idx] <= i_alloc_addr;
            slot_data[alloc_idx] <= i_alloc_data;
            slot_func[alloc_idx] <= i_alloc_lsu_func;
        end
    end

    always_comb begin
        cf_empty = (cf_wr_ptr == cf_rd_ptr);
        cf_head  = cfifo[cf_rd_ptr[IDX_W-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cf_wr_ptr <= '0;
            cf_rd_ptr <= '0;
        end else begin
            if (retire_hit)
                cf_wr_ptr <= cf_wr_ptr + (IDX_W + 1)'(1);
            if (drain_free)
                cf_rd_ptr <= cf_rd_ptr + (IDX_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (retire_hit)
            cfifo[cf_wr_ptr[IDX_W-1:0]] <= retire_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!cf_empty) state_nxt = S_WRITE;
            S_WRITE: begin
                if (i_dc_wr_done)
                    state_nxt = S_DONE;
                else if (i_dc_wr_retry)
                    state_nxt = S_RETRY;
            end
            S_RETRY: state_nxt = S_WRITE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_dc_wr_en     = (state == S_WRITE);
        o_sq_retire_en = (state == S_DONE);
        drain_free     = (state == S_DONE);
        latch_head     = (state == S_IDLE) && !cf_empty;
    end

    // Output registers hold their last value; only the enables carry meaning.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_idx            <= '0;
            o_dc_wr_addr         <= '0;
            o_dc_wr_data         <= '0;
            o_dc_wr_lsu_func     <= '0;
            o_sq_retire_addr     <= '0;
            o_sq_retire_lsu_func <= '0;
        end else begin
            if (latch_head) begin
                drain_idx        <= cf_head;
                o_dc_wr_addr     <= slot_addr[cf_head];
                o_dc_wr_data     <= slot_data[cf_head];
                o_dc_wr_lsu_func <= slot_func[cf_head];
            end
            if (state == S_WRITE && i_dc_wr_done) begin
                o_sq_retire_addr     <= o_dc_wr_addr;
                o_sq_retire_lsu_func <= o_dc_wr_lsu_func;
            end
        end
    end

endmodule
